// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, sends a start bit, shifts out
// one command byte with odd parity and a stop bit, then checks the device ack.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6500,
  parameter int TIMEOUT_CYCLES = 1300000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic [2:0] dbg_state
);

  // Handshake: a byte is accepted on a rising clk edge where tx_valid && tx_ready;
  // tx_ready is high only in IDLE, and tx_valid at any other time is dropped.

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    START     = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INHIBIT_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t          state;
  logic [7:0]      data_q;
  logic            parity_q;
  logic [3:0]      bit_cnt;
  logic [IW-1:0]   inhibit_cnt;
  logic [TW-1:0]   timeout_cnt;

  logic            clk_meta;
  logic            clk_sync;
  logic            clk_prev;
  logic            data_meta;
  logic            data_sync;

  logic            clk_fall;
  logic            frame_bit;
  logic            timed_state;
  logic            timeout_hit;

  assign dbg_state = state;

  // Lines idle high, so the synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk_in;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data_in;
      data_sync <= data_meta;
    end
  end

  assign clk_fall    = clk_prev & ~clk_sync;
  assign timed_state = (state == SHIFT) || (state == ACK) || (state == WAIT_IDLE);
  assign timeout_hit = timed_state && (timeout_cnt == TIMEOUT_LAST);

  // Bit to present after the falling edge numbered bit_cnt + 1.
  always_comb begin
    frame_bit = 1'b1;
    if (bit_cnt < 4'd8) begin
      frame_bit = data_q[bit_cnt[2:0]];
    end else if (bit_cnt == 4'd8) begin
      frame_bit = parity_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      data_q      <= '0;
      parity_q    <= 1'b0;
      bit_cnt     <= '0;
      inhibit_cnt <= '0;
      timeout_cnt <= '0;
      tx_ready    <= 1'b1;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;

      // Timeout wins over any edge seen in the same cycle.
      if (timeout_hit) begin
        state       <= IDLE;
        tx_error    <= 1'b1;
        tx_ready    <= 1'b1;
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
      end else begin
        if (timed_state) begin
          timeout_cnt <= timeout_cnt + 1'b1;
        end

        case (state)
          IDLE: begin
            if (tx_valid && tx_ready) begin
              data_q      <= tx_data;
              parity_q    <= ~^tx_data;
              inhibit_cnt <= '0;
              tx_ready    <= 1'b0;
              ps2_clk_oe  <= 1'b1;
              ps2_data_oe <= 1'b0;
              state       <= INHIBIT;
            end
          end

          INHIBIT: begin
            if (inhibit_cnt == INHIBIT_LAST) begin
              ps2_data_oe <= 1'b1;
              state       <= START;
            end else begin
              inhibit_cnt <= inhibit_cnt + 1'b1;
            end
          end

          START: begin
            ps2_clk_oe  <= 1'b0;
            bit_cnt     <= '0;
            timeout_cnt <= '0;
            state       <= SHIFT;
          end

          SHIFT: begin
            if (clk_fall) begin
              ps2_data_oe <= ~frame_bit;
              bit_cnt     <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd9) begin
                state <= ACK;
              end
            end
          end

          ACK: begin
            if (clk_fall) begin
              if (!data_sync) begin
                state <= WAIT_IDLE;
              end else begin
                tx_error <= 1'b1;
                tx_ready <= 1'b1;
                state    <= IDLE;
              end
            end
          end

          WAIT_IDLE: begin
            if (clk_sync && data_sync) begin
              tx_done  <= 1'b1;
              tx_ready <= 1'b1;
              state    <= IDLE;
            end
          end

          default: begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_ready    <= 1'b1;
            state       <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
